// File: rtl/router_pkg.sv
// Shared router constants and types: default channel/address/timeout sizing
// plus the index and address typedefs used by the FSM, FIFOs and sync block.
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;
  localparam int NUM_CH_MAX  = 8;

  typedef logic [$clog2(NUM_CH_MAX)-1:0] ch_idx_t;
  typedef logic [ADDR_W_DEF-1:0]         addr_t;

  // A header address selects a channel only when it names an existing FIFO.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned num_ch);
    return addr < num_ch;
  endfunction

endpackage

// File: rtl/router_stall_timer.sv
// Per-channel stall watchdog: counts cycles with valid data that nobody reads,
// emits a one-cycle soft_reset after TIMEOUT of them and keeps a sticky record.
module router_stall_timer #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic resetn,
  input  logic vld,
  input  logic read_enb,
  input  logic timeout_clr,
  output logic soft_reset,
  output logic timeout_status
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;
  logic             expire;

  assign stall  = vld && !read_enb;
  assign expire = stall && (cnt == CNT_LAST);

  // The counter clears on expiry, so it tops out at TIMEOUT-1 and cannot wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt            <= '0;
      soft_reset     <= 1'b0;
      timeout_status <= 1'b0;
    end else begin
      cnt            <= (stall && !expire) ? cnt + CNT_W'(1) : '0;
      soft_reset     <= expire;
      timeout_status <= soft_reset || (timeout_status && !timeout_clr);
    end
  end

endmodule

// File: rtl/router_sync_nch.sv
// Router synchroniser: latches the header address, steers the FSM write strobe
// to one FIFO, reports its full flag and runs a stall watchdog per channel.
module router_sync_nch
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic              timeout_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_status
);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_vld_q;
  logic              data_in_ok;

  assign data_in_ok = addr_in_range(32'(data_in), NUM_CH);

  // The validity bit is kept separately so the all-ones reset address stays
  // unusable even when all-ones happens to name a real channel.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= '1;
      addr_vld_q <= 1'b0;
      addr_err   <= 1'b0;
    end else if (detect_add) begin
      addr_q     <= data_in;
      addr_vld_q <= data_in_ok;
      addr_err   <= !data_in_ok;
    end
  end

  // NOTE: defaults at the top of the block keep every path assigned, so no
  // latches are inferred.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_timer
    router_stall_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk            (clk),
      .resetn         (resetn),
      .vld            (vld_out[ch]),
      .read_enb       (read_enb[ch]),
      .timeout_clr    (timeout_clr),
      .soft_reset     (soft_reset[ch]),
      .timeout_status (timeout_status[ch])
    );
  end

endmodule

// File: tb/tb_router_sync_nch.sv
// Bench for router_sync_nch: default and 4-channel/TIMEOUT=5 instances checked
// every cycle against a streak-length reference model, plus literal anchors.
module tb_router_sync_nch;

  localparam int NCH0 = 3;
  localparam int TO0  = 30;
  localparam int NCH1 = 4;
  localparam int TO1  = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       det[2], wer[2], tclr[2];
  logic [1:0] din[2];
  logic [7:0] emp[2], ful[2], rd[2];

  logic [2:0] we0, vld0, sr0, ts0;
  logic       ff0, ae0;
  logic [3:0] we1, vld1, sr1, ts1;
  logic       ff1, ae1;

  logic [7:0] we_o[2], vld_o[2], sr_o[2], ts_o[2];
  logic       ff_o[2], ae_o[2];
  assign we_o[0]  = 8'(we0);
  assign vld_o[0] = 8'(vld0);
  assign sr_o[0]  = 8'(sr0);
  assign ts_o[0]  = 8'(ts0);
  assign ff_o[0]  = ff0;
  assign ae_o[0]  = ae0;
  assign we_o[1]  = 8'(we1);
  assign vld_o[1] = 8'(vld1);
  assign sr_o[1]  = 8'(sr1);
  assign ts_o[1]  = 8'(ts1);
  assign ff_o[1]  = ff1;
  assign ae_o[1]  = ae1;

  router_sync_nch u_dut0 (
    .clk(clk), .resetn(resetn), .detect_add(det[0]), .data_in(din[0]),
    .write_enb_reg(wer[0]), .empty(emp[0][2:0]), .full(ful[0][2:0]),
    .read_enb(rd[0][2:0]), .timeout_clr(tclr[0]), .write_enb(we0),
    .fifo_full(ff0), .vld_out(vld0), .soft_reset(sr0), .addr_err(ae0),
    .timeout_status(ts0)
  );

  router_sync_nch #(.NUM_CH(NCH1), .ADDR_W(2), .TIMEOUT(TO1)) u_dut1 (
    .clk(clk), .resetn(resetn), .detect_add(det[1]), .data_in(din[1]),
    .write_enb_reg(wer[1]), .empty(emp[1][3:0]), .full(ful[1][3:0]),
    .read_enb(rd[1][3:0]), .timeout_clr(tclr[1]), .write_enb(we1),
    .fifo_full(ff1), .vld_out(vld1), .soft_reset(sr1), .addr_err(ae1),
    .timeout_status(ts1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nch(input int k);
    return (k == 0) ? NCH0 : NCH1;
  endfunction

  function automatic int tmo(input int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  // Reference model: address as an integer (-1 = nothing captured), and per
  // channel the length of the current unbroken stall streak. A pulse follows
  // every edge where the streak length is a positive multiple of the timeout.
  int m_addr[2];
  bit m_aerr[2];
  int streak[2][8];
  bit m_sr[2][8];
  bit m_ts[2][8];
  bit cmp_on = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        m_addr[k] = -1;
        m_aerr[k] = 1'b0;
        for (int c = 0; c < 8; c++) begin
          streak[k][c] = 0;
          m_sr[k][c]   = 1'b0;
          m_ts[k][c]   = 1'b0;
        end
      end else begin
        for (int c = 0; c < nch(k); c++) begin
          m_ts[k][c] = m_sr[k][c] || (m_ts[k][c] && !tclr[k]);
          if (!emp[k][c] && !rd[k][c]) streak[k][c]++;
          else streak[k][c] = 0;
          m_sr[k][c] = (streak[k][c] > 0) && (streak[k][c] % tmo(k) == 0);
        end
        if (det[k]) begin
          m_addr[k] = int'(din[k]);
          m_aerr[k] = int'(din[k]) >= nch(k);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        bit         valid;
        logic [7:0] mask, e_we, e_sr, e_ts;
        logic       e_ff;
        valid = (m_addr[k] >= 0) && (m_addr[k] < nch(k));
        mask  = 8'((1 << nch(k)) - 1);
        e_we  = (wer[k] && valid) ? 8'(1 << m_addr[k]) : 8'h00;
        e_ff  = valid ? ful[k][m_addr[k]] : 1'b0;
        e_sr  = '0;
        e_ts  = '0;
        for (int c = 0; c < nch(k); c++) begin
          e_sr[c] = m_sr[k][c];
          e_ts[c] = m_ts[k][c];
        end
        check($sformatf("i%0d_write_enb", k), we_o[k], e_we);
        check($sformatf("i%0d_fifo_full", k), ff_o[k], e_ff);
        check($sformatf("i%0d_vld_out", k), vld_o[k], ~emp[k] & mask);
        check($sformatf("i%0d_soft_reset", k), sr_o[k], e_sr);
        check($sformatf("i%0d_timeout_status", k), ts_o[k], e_ts);
        check($sformatf("i%0d_addr_err", k), ae_o[k], m_aerr[k]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      det[k]  = 1'b0;
      wer[k]  = 1'b0;
      tclr[k] = 1'b0;
      din[k]  = 2'd0;
      emp[k]  = 8'hff;
      ful[k]  = 8'h00;
      rd[k]   = 8'h00;
    end
  endtask

  initial begin
    idle();
    ful[0] = 8'hff;
    ful[1] = 8'hff;
    wer[0] = 1'b1;
    wer[1] = 1'b1;
    emp[0] = 8'b1111_1101;
    resetn = 1'b0;
    tick(2);
    cmp_on = 1'b1;
    check("rst_write_enb0", we0, 3'b000);
    check("rst_write_enb1", we1, 4'b0000);
    check("rst_fifo_full1", ff1, 1'b0);
    check("rst_vld_out0", vld0, 3'b010);
    check("rst_addr_err0", ae0, 1'b0);
    check("rst_status0", ts0, 3'b000);

    resetn = 1'b1;
    idle();
    tick(1);

    // Capture address 2, then request a write.
    din[0] = 2'd2;
    det[0] = 1'b1;
    tick(1);
    det[0] = 1'b0;
    wer[0] = 1'b1;
    ful[0] = 8'b0000_0100;
    #1;
    check("addr2_write_enb", we0, 3'b100);
    check("addr2_fifo_full", ff0, 1'b1);

    din[0] = 2'd3;
    det[0] = 1'b1;
    tick(1);
    det[0] = 1'b0;
    #1;
    check("addr3_addr_err", ae0, 1'b1);
    check("addr3_write_enb", we0, 3'b000);
    din[0] = 2'd0;
    det[0] = 1'b1;
    tick(1);
    det[0] = 1'b0;
    #1;
    check("addr0_addr_err", ae0, 1'b0);
    check("addr0_write_enb", we0, 3'b001);
    wer[0] = 1'b0;
    ful[0] = 8'h00;

    // Channel 1 stalls for 61 cycles: pulses on cycles 31 and 61.
    emp[0] = 8'b1111_1101;
    tick(30);
    check("stall_c31_pulse", sr0, 3'b010);
    tick(1);
    check("stall_c32_pulse", sr0, 3'b000);
    check("stall_c32_status", ts0[1], 1'b1);
    tick(28);
    check("stall_c60_pulse", sr0, 3'b000);
    tick(1);
    check("stall_c61_pulse", sr0, 3'b010);
    emp[0] = 8'hff;
    tclr[0] = 1'b1;
    tick(2);
    tclr[0] = 1'b0;

    // Channel 0: a read on the 30th cycle suppresses the pulse.
    emp[0] = 8'b1111_1110;
    tick(29);
    rd[0] = 8'h01;
    tick(1);
    rd[0] = 8'h00;
    check("read_c30_nopulse", sr0, 3'b000);
    tick(29);
    check("rearm_c29_nopulse", sr0, 3'b000);
    tick(1);
    check("rearm_c30_pulse", sr0, 3'b001);
    emp[0] = 8'hff;
    tick(2);

    // Channel 2: reset on stall cycle 20 discards progress.
    emp[0] = 8'b1111_1011;
    tick(19);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(29);
    check("post_rst_nopulse", sr0, 3'b000);
    tick(1);
    check("post_rst_pulse", sr0, 3'b100);
    tclr[0] = 1'b1;
    tick(1);
    tclr[0] = 1'b0;
    check("clr_vs_set_status", ts0[2], 1'b1);
    tclr[0] = 1'b1;
    tick(1);
    tclr[0] = 1'b0;
    check("clr_status", ts0[2], 1'b0);
    emp[0] = 8'hff;
    tick(2);

    // Four-channel instance: address 3 and simultaneous timeouts.
    din[1] = 2'd3;
    det[1] = 1'b1;
    tick(1);
    det[1] = 1'b0;
    wer[1] = 1'b1;
    #1;
    check("nch4_write_enb", we1, 4'b1000);
    check("nch4_addr_err", ae1, 1'b0);
    wer[1] = 1'b0;
    emp[1] = 8'b1111_0110;
    tick(5);
    check("nch4_dual_pulse", sr1, 4'b1001);
    emp[1] = 8'hff;
    tick(2);

    for (int n = 0; n < 4000; n++) begin
      resetn = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 2; k++) begin
        det[k]  = ($urandom_range(0, 3) == 0);
        din[k]  = 2'($urandom);
        wer[k]  = 1'($urandom);
        tclr[k] = ($urandom_range(0, 15) == 0);
        ful[k]  = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
          if ($urandom_range(0, 63) == 0) emp[k][c] = ~emp[k][c];
          rd[k][c] = ($urandom_range(0, 39) == 0);
        end
      end
      tick(1);
    end

    resetn = 1'b1;
    idle();
    tick(2);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
